// File: rtl/spike_word_replay.sv
// spike_word_replay
// Buffers 16-bit raw spike words {sync, group_idx, chan_flags} arriving over a
// valid/ready handshake and replays each word's channel flags during the
// 16-cycle slot of its group in the time-multiplexed neuron loop.
// Optional build macro: SPIKE_REPLAY_LOOP_EN adds a loop_mode input that makes
// the buffered pattern repeat by re-pushing every popped word at the tail.
module spike_word_replay #(
    parameter int NN    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            neuron_clk,
    input  logic            reset_sim,
    input  logic [NN+2:0]   neuron_counter,
    input  logic [15:0]     in_word,
    input  logic            in_valid,
`ifdef SPIKE_REPLAY_LOOP_EN
    input  logic            loop_mode,
`endif
    output logic            in_ready,
    output logic [7:0]      spike_out,
    output logic            frame_start,
    output logic [AW:0]     fill_level,
    output logic            busy
);

    // Stored entry keeps only the bits the decoder uses: {sync, idx, flags}.
    localparam int EW = NN + 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        FIRE,
        WSYNC
    } state_t;

    state_t            state_reg, state_next;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     hold_reg;
    logic [EW-1:0]     wr_data;
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0]     load_addr;
    logic [AW:0]       fill_reg;
    logic [7:0]        spike_reg;
    logic              frame_reg;

    logic              loop_active;
    logic              push, pop, wr_en, load_hold, fire, chain;
    logic              hold_sync;
    logic [NN-2:0]     hold_idx;
    logic [NN-2:0]     slot;
    logic [3:0]        phase;
    logic              match;
    logic              counter_zero;

`ifdef SPIKE_REPLAY_LOOP_EN
    assign loop_active = loop_mode;
`else
    assign loop_active = 1'b0;
`endif

    // With a narrower neuron array the upper group-index bits are ignored.
    generate
        if (NN < 8) begin : g_unused_idx
            logic unused_idx_bits;
            assign unused_idx_bits = ^in_word[14:NN+7];
        end
    endgenerate

    assign in_ready     = (fill_reg != (AW+1)'(DEPTH)) && !loop_active;
    assign push         = in_valid && in_ready;
    // In loop mode the popped word goes straight back to the tail.
    assign wr_en        = push || (pop && loop_active);
    assign wr_data      = (pop && loop_active) ? hold_reg
                                               : {in_word[15], in_word[NN+6:8], in_word[7:0]};

    assign hold_sync    = hold_reg[EW-1];
    assign hold_idx     = hold_reg[EW-2:8];
    assign slot         = neuron_counter[NN+2:4];
    assign phase        = neuron_counter[3:0];
    assign counter_zero = (neuron_counter == '0);
    assign match        = (slot == hold_idx) && (phase == 4'h0);
    // More than the word being popped is buffered: next word can load immediately.
    assign chain        = (fill_reg > (AW+1)'(1));

    assign spike_out    = spike_reg;
    assign frame_start  = frame_reg;
    assign fill_level   = fill_reg;
    assign busy         = (state_reg != IDLE);

    // Word storage: write-only array, read through the registered hold word.
    always_ff @(posedge neuron_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; reset flushes the buffer.
    always_ff @(posedge neuron_clk) begin
        if (reset_sim) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (wr_en && !pop) begin
                fill_reg <= fill_reg + (AW+1)'(1);
            end else if (pop && !wr_en) begin
                fill_reg <= fill_reg - (AW+1)'(1);
            end
        end
    end

    // State register, hold word and registered outputs.
    always_ff @(posedge neuron_clk) begin
        if (reset_sim) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            spike_reg <= '0;
            frame_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_hold) begin
                hold_reg <= mem[load_addr];
            end
            spike_reg <= fire ? hold_reg[7:0] : 8'h00;
            frame_reg <= counter_zero;
        end
    end

    // Next-state logic. Popping a word loads the following entry in the same
    // cycle so consecutive groups replay without a gap. LOAD always moves to
    // WAIT because the hold word is only visible once registered; WAIT then
    // hands sync words to WSYNC, handling a frame start that lands on that
    // very cycle so no wrap is missed.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        load_hold  = 1'b0;
        load_addr  = rd_ptr_reg;
        fire       = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (fill_reg != '0) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                load_hold  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (hold_sync) begin
                    if (counter_zero) begin
                        pop        = 1'b1;
                        load_hold  = chain;
                        load_addr  = rd_ptr_reg + AW'(1);
                        state_next = chain ? WAIT : IDLE;
                    end else begin
                        state_next = WSYNC;
                    end
                end else if (match) begin
                    fire       = 1'b1;
                    state_next = FIRE;
                end
            end
            FIRE: begin
                fire = 1'b1;
                if (phase == 4'hF) begin
                    pop        = 1'b1;
                    load_hold  = chain;
                    load_addr  = rd_ptr_reg + AW'(1);
                    state_next = chain ? WAIT : IDLE;
                end
            end
            WSYNC: begin
                if (counter_zero) begin
                    pop        = 1'b1;
                    load_hold  = chain;
                    load_addr  = rd_ptr_reg + AW'(1);
                    state_next = chain ? WAIT : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spike_word_replay.sv
// Testbench for spike_word_replay: drives the neuron-loop counter, pushes raw
// words and checks spike_out every cycle against a scoreboard of expected
// bursts {first visible cycle, length, flags}.
module tb_spike_word_replay;

    localparam int NN    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 2048;

    logic            neuron_clk = 1'b0;
    logic            reset_sim;
    logic [NN+2:0]   neuron_counter;
    logic [15:0]     in_word;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      spike_out;
    logic            frame_start;
    logic [AW:0]     fill_level;
    logic            busy;
`ifdef SPIKE_REPLAY_LOOP_EN
    logic            loop_mode;
`endif

    typedef struct {
        int unsigned start;
        int unsigned len;
        logic [7:0]  flags;
    } burst_t;

    burst_t      sb[$];
    int unsigned cyc;
    bit          freeze;
    int          checks;
    int          errors;

    always #5 neuron_clk = ~neuron_clk;

    spike_word_replay #(.NN(NN), .DEPTH(DEPTH), .AW(AW)) dut (
        .neuron_clk     (neuron_clk),
        .reset_sim      (reset_sim),
        .neuron_counter (neuron_counter),
        .in_word        (in_word),
        .in_valid       (in_valid),
`ifdef SPIKE_REPLAY_LOOP_EN
        .loop_mode      (loop_mode),
`endif
        .in_ready       (in_ready),
        .spike_out      (spike_out),
        .frame_start    (frame_start),
        .fill_level     (fill_level),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            if (errors <= 40) begin
                $display("FAIL %s observed=%0h expected=%0h (cyc %0d counter %h)",
                         tag, obs, exp, cyc, neuron_counter);
            end
        end
    endtask

    // One clock: advance the loop counter, then compare the registered outputs.
    task automatic step();
        logic       prev_zero;
        logic [7:0] exp_sp;
        bit         done;
        prev_zero = (neuron_counter == '0) && !reset_sim;
        @(posedge neuron_clk);
        #1;
        if (!freeze) begin
            cyc++;
            neuron_counter = cyc[NN+2:0];
        end
        exp_sp = 8'h00;
        done   = 1'b0;
        if (sb.size() > 0 && cyc >= sb[0].start) begin
            exp_sp = sb[0].flags;
            done   = (cyc == sb[0].start + sb[0].len - 1);
        end
        check("spike_out", spike_out, exp_sp);
        check("frame_start", frame_start, prev_zero);
        if (done) begin
            $display("burst flags=%h ended at counter %h", sb[0].flags, neuron_counter);
            void'(sb.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_counter(input logic [NN+2:0] v);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME && !found; n++) begin
            if (neuron_counter == v) found = 1'b1;
            else step();
        end
        if (!found) check("wait_counter_timeout", neuron_counter, v);
    endtask

    task automatic expect_burst(input int unsigned start, input int unsigned len,
                                input logic [7:0] flags);
        burst_t b;
        b.start = start;
        b.len   = len;
        b.flags = flags;
        sb.push_back(b);
    endtask

    task automatic push(input logic [15:0] w);
        bit ok;
        ok       = 1'b0;
        in_word  = w;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !ok; n++) begin
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 32'd0, 32'd1);
        $display("push word=%h accepted=%0d counter=%h fill=%0d", w, ok, neuron_counter, fill_level);
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 5 * FRAME && sb.size() > 0; n++) step();
        check({tag, "_pending"}, sb.size(), 0);
        run(4);
        check({tag, "_fill"}, fill_level, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, in_ready, 1);
    endtask

    initial begin
        int unsigned base;
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        freeze         = 1'b0;
        neuron_counter = '0;
        in_word        = '0;
        in_valid       = 1'b0;
        reset_sim      = 1'b1;
`ifdef SPIKE_REPLAY_LOOP_EN
        loop_mode      = 1'b0;
`endif

        // Reset held for two cycles.
        run(2);
        reset_sim = 1'b0;
        check("rst_spike", spike_out, 0);
        check("rst_fill", fill_level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);

        // Single word for group 5 pushed at frame start.
        wait_counter(11'h000);
        base = cyc;
        expect_burst(base + 32'h51, 16, 8'h40);
        push(16'h0540);
        check("t2_fill_after_push", fill_level, 1);
        drain("t2");

        // Group 3 already passed when pushed: plays in the next frame.
        wait_counter(11'h100);
        base = cyc - 32'h100;
        expect_burst(base + FRAME + 32'h31, 16, 8'h80);
        push(16'h0380);
        drain("t3");

        // Fill the buffer with the counter frozen, then replay back to back.
        wait_counter(11'h7F0);
        freeze = 1'b1;
        base   = cyc + 16;
        for (int i = 0; i < DEPTH; i++) begin
            expect_burst(base + 32'(i) * 16 + 1, 16, 8'(8'h10 + i));
            push({1'b0, 7'(i), 8'(8'h10 + i)});
        end
        in_word  = 16'h0F77;
        in_valid = 1'b1;
        check("t4_ready_full", in_ready, 0);
        check("t4_fill_full", fill_level, DEPTH);
        check("t4_busy", busy, 1);
        run(3);
        check("t4_fill_hold", fill_level, DEPTH);
        in_valid = 1'b0;
        freeze   = 1'b0;
        drain("t4");

        // Sync word consumes the next frame start; the group-0 slot coinciding
        // with that pop is gone, so the data word plays one frame later.
        wait_counter(11'h010);
        base = cyc - 32'h10;
        expect_burst(base + 2 * FRAME + 1, 16, 8'h20);
        push(16'h8000);
        push(16'h0020);
        check("t5_fill", fill_level, 2);
        drain("t5");

        // Reset on the fifth FIRE cycle truncates the burst after four outputs.
        wait_counter(11'h000);
        base = cyc;
        expect_burst(base + 32'h51, 4, 8'h40);
        push(16'h0540);
        wait_counter(11'h054);
        reset_sim = 1'b1;
        step();
        reset_sim = 1'b0;
        check("t6_spike_cleared", spike_out, 0);
        check("t6_fill", fill_level, 0);
        check("t6_busy", busy, 0);
        run(FRAME + 128);
        drain("t6");

`ifdef SPIKE_REPLAY_LOOP_EN
        // Loop mode: one buffered word repeats every frame.
        wait_counter(11'h000);
        base = cyc;
        for (int k = 0; k < 3; k++) expect_burst(base + 32'(k) * FRAME + 32'h51, 16, 8'h40);
        push(16'h0540);
        loop_mode = 1'b1;
        for (int n = 0; n < 3 * FRAME && cyc < base + 2 * FRAME + 32'h51; n++) begin
            check("loop_fill", fill_level, 1);
            check("loop_ready", in_ready, 0);
            step();
        end
        loop_mode = 1'b0;
        drain("loop");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
